// File: rtl/load_hazard_ctrl.sv
// Load-use interlock beside ID: tracks in-flight loads, stalls dependents.
// Optional HAZ_PERF_CNT_EN adds stall_cnt/freeze_cnt perf counters.
module load_hazard_ctrl #(
  parameter int REG_AW         = 5,
  parameter int LOAD_LAT       = 1,
  parameter int STORE_DATA_FWD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_op,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_redirect,
  input  logic              mem_ready,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       freeze_cnt,
`endif
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_kill,
  output logic              pipe_freeze
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic [LOAD_LAT-1:0]             tv;
  logic [LOAD_LAT-1:0][REG_AW-1:0] trd;

  logic use1;
  logic use2;
  logic match;
  logic hazard;
  logic freeze;
  logic redir;
  logic stall;
  logic is_load;

  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (1'b1)
      id_op == OP_R: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      id_op == OP_BR: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      id_op == OP_STORE: begin
        use1 = 1'b1;
        use2 = (STORE_DATA_FWD == 0);
      end
      id_op == OP_I:    use1 = 1'b1;
      id_op == OP_LOAD: use1 = 1'b1;
      id_op == OP_JALR: use1 = 1'b1;
      default: begin
        use1 = 1'b0;
        use2 = 1'b0;
      end
    endcase
  end

  // any live load whose rd feeds a used source interlocks
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (tv[k] && (trd[k] != '0) &&
          ((use1 && (trd[k] == id_rs1)) ||
           (use2 && (trd[k] == id_rs2))))
        match = 1'b1;
    end
  end

  assign hazard  = id_valid & match;
  assign is_load = id_valid & (id_op == OP_LOAD);
  assign freeze  = rst_n & ~mem_ready;
  assign redir   = rst_n & mem_ready & ex_redirect;
  assign stall   = rst_n & mem_ready & ~ex_redirect & hazard;

  assign pc_hold     = freeze | stall;
  assign ifid_hold   = freeze | stall;
  assign ifid_flush  = redir;
  assign idex_kill   = redir | stall;
  assign pipe_freeze = freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv  <= '0;
      trd <= '0;
    end else if (mem_ready) begin
      for (int k = 1; k < LOAD_LAT; k++) begin
        tv[k]  <= tv[k-1];
        trd[k] <= trd[k-1];
      end
      tv[0]  <= (redir | stall) ? 1'b0 : is_load;
      trd[0] <= id_rd;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stall)  stall_cnt  <= stall_cnt + 32'd1;
      if (freeze) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// Directed bench for load_hazard_ctrl across three parameter sets.
// Instance 0: LAT1/FWD1, 1: LAT2/FWD1, 2: LAT1/FWD0.
module tb_load_hazard_ctrl;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] IA  = 7'b0010011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] JAL = 7'b1101111;

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_STALL = 5'b11010;
  localparam logic [4:0] O_FRZ   = 5'b11001;
  localparam logic [4:0] O_REDIR = 5'b00110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_op;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic       ex_redirect;
  logic       mem_ready;

  logic [4:0]  o   [3];
  logic [31:0] sc  [3];
  logic [31:0] fc  [3];
  int          sel;
  logic [4:0]  obs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign obs = o[sel];

`ifndef HAZ_PERF_CNT_EN
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sc[i] = '0;
      fc[i] = '0;
    end
  end
`endif

  load_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(1),
    .STORE_DATA_FWD(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op),
    .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .ex_redirect(ex_redirect),
    .mem_ready(mem_ready),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(sc[0]), .freeze_cnt(fc[0]),
`endif
    .pc_hold(o[0][4]), .ifid_hold(o[0][3]),
    .ifid_flush(o[0][2]),
    .idex_kill(o[0][1]),
    .pipe_freeze(o[0][0])
  );

  load_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(2),
    .STORE_DATA_FWD(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op),
    .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .ex_redirect(ex_redirect),
    .mem_ready(mem_ready),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(sc[1]), .freeze_cnt(fc[1]),
`endif
    .pc_hold(o[1][4]), .ifid_hold(o[1][3]),
    .ifid_flush(o[1][2]),
    .idex_kill(o[1][1]),
    .pipe_freeze(o[1][0])
  );

  load_hazard_ctrl #(
    .REG_AW(5), .LOAD_LAT(1),
    .STORE_DATA_FWD(0)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op),
    .id_rd(id_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .ex_redirect(ex_redirect),
    .mem_ready(mem_ready),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(sc[2]), .freeze_cnt(fc[2]),
`endif
    .pc_hold(o[2][4]), .ifid_hold(o[2][3]),
    .ifid_flush(o[2][2]),
    .idex_kill(o[2][1]),
    .pipe_freeze(o[2][0])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    id_valid    = 1'b0;
    id_op       = '0;
    id_rd       = '0;
    id_rs1      = '0;
    id_rs2      = '0;
    ex_redirect = 1'b0;
    mem_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = 1'b1;
    id_op    = op;
    id_rd    = rd;
    id_rs1   = rs1;
    id_rs2   = rs2;
  endtask

  // present one instruction, expect n stall cycles, then issue
  task automatic issue(input string tag, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input int n);
    drive(op, rd, rs1, rs2);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, {27'd0, obs}, {27'd0, O_STALL});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk({tag, "_go"}, {27'd0, obs}, {27'd0, O_IDLE});
    @(posedge clk);
    #1;
  endtask

  initial begin
    sel = 0;
    do_reset();
    @(negedge clk);
    chk("reset0", {27'd0, o[0]}, 32'd0);
    chk("reset1", {27'd0, o[1]}, 32'd0);
    chk("reset2", {27'd0, o[2]}, 32'd0);

    // LOAD_LAT=1 basic load-use
    sel = 0;
    do_reset();
    issue("l1_lw", LD, 5, 2, 0, 0);
    issue("l1_add", RR, 6, 5, 1, 1);

    // LOAD_LAT=2 immediate and one-slot-later dependents
    sel = 1;
    do_reset();
    issue("l2_lw", LD, 5, 2, 0, 0);
    issue("l2_add", RR, 6, 5, 1, 2);
    do_reset();
    issue("l2b_lw", LD, 5, 2, 0, 0);
    issue("l2b_addi", IA, 7, 0, 0, 0);
    issue("l2b_add", RR, 6, 5, 1, 1);

    // back-to-back loads, older one still governs
    do_reset();
    issue("bb_lw1", LD, 5, 2, 0, 0);
    issue("bb_lw2", LD, 8, 3, 0, 0);
    issue("bb_add", RR, 6, 5, 9, 1);

    // x0 and no-use cases
    sel = 0;
    do_reset();
    issue("x0_lw", LD, 0, 2, 0, 0);
    issue("x0_add", RR, 6, 0, 0, 0);
    do_reset();
    issue("lui_lw", LD, 5, 2, 0, 0);
    issue("lui", LUI, 5, 5, 5, 0);
    do_reset();
    issue("jal_lw", LD, 5, 2, 0, 0);
    issue("jal", JAL, 1, 5, 5, 0);

    // store data forwarding
    do_reset();
    issue("sd_lw", LD, 5, 2, 0, 0);
    issue("sd_sw", ST, 0, 2, 5, 0);
    do_reset();
    issue("sa_lw", LD, 5, 2, 0, 0);
    issue("sa_sw", ST, 0, 5, 1, 1);
    sel = 2;
    do_reset();
    issue("nf_lw", LD, 5, 2, 0, 0);
    issue("nf_sw", ST, 0, 2, 5, 1);

    // freeze during a load-use stall
    sel = 1;
    do_reset();
    issue("fz_lw", LD, 5, 2, 0, 0);
    drive(RR, 6, 5, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fz_freeze", {27'd0, obs}, {27'd0, O_FRZ});
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    issue("fz_add", RR, 6, 5, 1, 2);
`ifdef HAZ_PERF_CNT_EN
    chk("fz_stall_cnt", sc[1], 32'd2);
    chk("fz_freeze_cnt", fc[1], 32'd3);
`endif

    // redirect beats a hazard
    sel = 0;
    do_reset();
    issue("rd_lw", LD, 5, 2, 0, 0);
    drive(RR, 6, 5, 1);
    ex_redirect = 1'b1;
    @(negedge clk);
    chk("rd_redir", {27'd0, obs}, {27'd0, O_REDIR});
    @(posedge clk);
    #1 ex_redirect = 1'b0;
    issue("rd_after", RR, 6, 5, 1, 0);

    // reset mid-stall
    sel = 1;
    do_reset();
    issue("rs_lw", LD, 5, 2, 0, 0);
    drive(RR, 6, 5, 1);
    @(negedge clk);
    chk("rs_stall", {27'd0, obs}, {27'd0, O_STALL});
    #1 rst_n = 1'b0;
    #1 chk("rs_async", {27'd0, obs}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue("rs_after", RR, 6, 5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
